// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, stop bit,
// delivered through a one-deep valid/ready buffer with framing/overrun flags.
module serial_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             din,
  input  logic             bit_en,
  input  logic             ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             frame_err_reg, frame_err_next;
  logic             overrun_reg, overrun_next;

  logic stop_edge, good_stop, buf_free, load;

  // Right shift with the new bit entering at the MSB, so the first (LSB) bit
  // ends up at position 0 after WIDTH shifts.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign shifted[gi] = shift_reg[gi+1];
    end
  endgenerate
  assign shifted[WIDTH-1] = din;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    if (bit_en) begin
      case (state_reg)
        IDLE: begin
          if (!din) begin
            cnt_next   = '0;
            state_next = DATA;
          end
        end
        DATA: begin
          shift_next = shifted;
          cnt_next   = cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) state_next = STOP;
        end
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign stop_edge = bit_en && (state_reg == STOP);
  assign good_stop = stop_edge && din;
  assign buf_free  = !valid_reg || ready;
  assign load      = good_stop && buf_free;

  always_comb begin
    data_next      = load ? shift_reg : data_reg;
    valid_next     = valid_reg;
    if (load)       valid_next = 1'b1;
    else if (ready) valid_next = 1'b0;
    frame_err_next = stop_edge && !din;
    // A fresh overrun takes precedence over a same-edge clear request.
    overrun_next   = overrun_reg;
    if (good_stop && !buf_free) overrun_next = 1'b1;
    else if (err_clr)           overrun_next = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: table of single frames plus hand-written
// overrun, drain/load, sparse-enable and mid-frame reset sequences.
module tb_serial_frame_rx;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       din = 1'b1;
  logic       bit_en = 1'b0;
  logic       ready = 1'b1;
  logic       err_clr = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  int tests = 0;
  int fails = 0;

  serial_frame_rx #(.WIDTH(8)) dut (
    .clock(clock), .clear(clear), .din(din), .bit_en(bit_en), .ready(ready),
    .err_clr(err_clr), .data(data), .valid(valid), .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] payload;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din = b;
    bit_en = 1'b1;
    step();
    bit_en = 1'b0;
  endtask

  // Start bit plus eight data bits LSB-first; the stop bit is sent by the caller.
  task automatic send_body(input logic [7:0] p);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(p[i]);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d, input logic v,
                         input logic fe, input logic ov);
    chk({tag, ".data"}, {8'h0, data}, {8'h0, d});
    chk({tag, ".valid"}, {15'h0, valid}, {15'h0, v});
    chk({tag, ".frame_err"}, {15'h0, frame_err}, {15'h0, fe});
    chk({tag, ".overrun"}, {15'h0, overrun}, {15'h0, ov});
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 8'hA5, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h81, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0};

    step();
    step();
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    clear = 1'b1;

    // Table: ready held high, so a loaded word lives for exactly one cycle.
    ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      send_body(vecs[v].payload);
      send_bit(vecs[v].stop);
      $display("[TB] vec %0d payload=%02h stop=%0b -> data=%02h valid=%0b frame_err=%0b",
               v, vecs[v].payload, vecs[v].stop, data, valid, frame_err);
      chk_all($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_valid,
              vecs[v].exp_ferr, 1'b0);
      step();
      chk($sformatf("vec%0d.valid_after", v), {15'h0, valid}, 16'h0);
      chk($sformatf("vec%0d.ferr_after", v), {15'h0, frame_err}, 16'h0);
    end

    // Overrun: buffer held full, second frame dropped.
    ready = 1'b0;
    send_body(8'h11);
    send_bit(1'b1);
    $display("[TB] overrun first frame 11 -> data=%02h valid=%0b", data, valid);
    chk_all("ovr_first", 8'h11, 1'b1, 1'b0, 1'b0);
    send_body(8'h22);
    send_bit(1'b1);
    $display("[TB] overrun second frame 22 -> data=%02h overrun=%0b", data, overrun);
    chk_all("ovr_second", 8'h11, 1'b1, 1'b0, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    $display("[TB] err_clr -> overrun=%0b", overrun);
    chk_all("ovr_clear", 8'h11, 1'b1, 1'b0, 1'b0);

    // err_clr on the same edge as a new overrun: the overrun wins.
    send_body(8'h33);
    err_clr = 1'b1;
    send_bit(1'b1);
    err_clr = 1'b0;
    $display("[TB] overrun with err_clr frame 33 -> overrun=%0b", overrun);
    chk_all("ovr_vs_clr", 8'h11, 1'b1, 1'b0, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovr_clear2", {15'h0, overrun}, 16'h0);

    // Simultaneous drain and load on the stop-bit edge.
    send_body(8'h22);
    ready = 1'b1;
    send_bit(1'b1);
    ready = 1'b0;
    $display("[TB] drain+load frame 22 -> data=%02h valid=%0b overrun=%0b", data, valid, overrun);
    chk_all("drain_load", 8'h22, 1'b1, 1'b0, 1'b0);
    ready = 1'b1;
    step();
    chk("drain_after", {15'h0, valid}, 16'h0);
    ready = 1'b0;

    // Sparse enable: one enabled cycle in three, junk on disabled cycles.
    begin
      logic [9:0] bits;
      bits = {1'b1, 8'h5A, 1'b0};
      for (int i = 0; i < 10; i++) begin
        send_bit(bits[i]);
        for (int k = 0; k < 2; k++) begin
          din = 1'($urandom_range(0, 1));
          step();
        end
      end
    end
    $display("[TB] sparse frame 5A -> data=%02h valid=%0b", data, valid);
    chk_all("sparse", 8'h5A, 1'b1, 1'b0, 1'b0);

    // Reset after four data bits of a frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    clear = 1'b0;
    step();
    $display("[TB] mid-frame reset -> data=%02h valid=%0b", data, valid);
    chk_all("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
    clear = 1'b1;
    ready = 1'b1;
    send_body(8'hC3);
    send_bit(1'b1);
    $display("[TB] post-reset frame C3 -> data=%02h valid=%0b", data, valid);
    chk_all("post_reset", 8'hC3, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Receive-side framer that consumes the serial bit stream produced by the single-bit `dff` sampling stage and assembles it into parallel operand words for the 8-bit ALU datapath. It detects a start bit, shifts in WIDTH data bits LSB-first, checks the stop bit, and presents each good word through a one-deep valid/ready output buffer. Framing errors and buffer overruns are reported as flags.

## Interface
- `WIDTH`, 8, data bits per frame; legal range 2..16.
- `clock`  input  1  rising-edge clock; all state changes on its rising edge.
- `clear`  input  1  synchronous, active-low reset, sampled on the rising edge of `clock`.
- `din`  input  1  serial bit, the registered `q` of the upstream `dff`.
- `bit_en`  input  1  `din` is sampled only on edges where `bit_en`=1; other edges hold all frame state.
- `ready`  input  1  consumer accepts `data` on an edge where `valid`=1 and `ready`=1.
- `err_clr`  input  1  clears the sticky `overrun` flag.
- `data`  output  WIDTH  last accepted frame payload; stable while `valid`=1.
- `valid`  output  1  `data` holds an unconsumed word.
- `frame_err`  output  1  one-cycle pulse: the stop bit sampled as 0.
- `overrun`  output  1  sticky: a good frame was dropped because the buffer was full.

## Operation
- Frame format on sampled bits: start bit 0, then WIDTH data bits with the LSB first, then stop bit 1.
- Bit counter width is `$clog2(WIDTH+1)`. The shift register is WIDTH bits and shifts right, with `din` entering at the MSB.
- State machine states: IDLE, DATA, STOP.
  - IDLE: on `bit_en`=1 with `din`=0, clear the counter and go to DATA. With `din`=1, stay in IDLE.
  - DATA: on each `bit_en`=1, shift in `din` and increment the counter. After the WIDTH-th bit, go to STOP.
  - STOP: on `bit_en`=1, always return to IDLE. Then:
    - `din`=1 and the buffer is free: load `data` from the shift register and set `valid`.
    - `din`=1 and the buffer is full: drop the word, set `overrun`, leave `data` and `valid` unchanged.
    - `din`=0: pulse `frame_err` for one cycle and drop the word. `valid` and `data` are unchanged.
- Buffer-free condition: `valid`=0, or `valid`=1 and `ready`=1 on the same edge. A simultaneous drain and load replaces `data`, keeps `valid`=1, and does not set `overrun`.
- `valid` clears on an edge with `ready`=1 and no simultaneous load.
- `overrun` clears only on an `err_clr`=1 edge or on reset. If `err_clr` and a new overrun occur on the same edge, the overrun wins and the flag stays 1.
- `bit_en`=0 freezes the state, counter and shift register. The handshake and `err_clr` still operate.
- A start bit may be sampled on the first `bit_en` after STOP exits, so back-to-back frames need no idle gap.

## Timing
- Reset (`clear`=0 at an edge): state=IDLE, counter=0, shift register=0, `data`=0, `valid`=0, `frame_err`=0, `overrun`=0. Reset has priority over every other input.
- Reset mid-frame discards the partial frame. The first sample after `clear` returns to 1 is treated as IDLE.
- A frame uses WIDTH+2 sampled bits. With `bit_en` held at 1, one frame takes WIDTH+2 clocks.
- Latency: `valid` and `data` update on the same edge that samples the stop bit. They are visible in the following cycle.
- `frame_err` is high for exactly the one cycle after the bad stop bit is sampled.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Good frame: `bit_en`=1, `ready`=1, serial 0,1,0,1,0,0,1,0,1,1 (0xA5 LSB-first) → `data`=0xA5 and `valid`=1 for exactly one cycle, 10 clocks after the start bit.
- Framing error: send 0x3C with stop bit 0 → `frame_err` pulses once, `valid` stays 0, `data` keeps its prior value.
- Overrun: `ready`=0, send 0x11 then 0x22 back-to-back → `data`=0x11 and `valid`=1 held, `overrun`=1 after the second stop bit. Then `err_clr` for one cycle → `overrun`=0.
- Simultaneous drain and load: hold 0x11 with `valid`=1 and raise `ready` on exactly the stop-bit edge of 0x22 → `data`=0x22, `valid`=1, `overrun`=0.
- Sparse enable: send 0x5A with `bit_en` high one cycle in three and random `din` on disabled cycles → `data`=0x5A.
- Reset mid-frame: assert `clear`=0 after 4 data bits, release, then send 0xC3 → all outputs are 0 during reset, then `data`=0xC3 with no error flags.
